// File: rtl/window_tap_serializer_if.sv
// Bundle of window-side and stream-side handshake signals for window_tap_serializer.
// The slave modport is the serializer's view; master is the surrounding logic's view.
interface window_tap_serializer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_SIZE = 32,
  parameter int NUM_CH      = 4,
  parameter int KERNEL_SIZE = 4,
  parameter int DIL_W       = 5
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAP_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  logic signed [DATA_WIDTH-1:0] window_in [0:NUM_CH-1][0:WINDOW_SIZE-1];
  logic                         window_valid;
  logic                         window_ready;
  logic                         cfg_mode;
  logic [DIL_W-1:0]             cfg_dilation;
  logic signed [DATA_WIDTH-1:0] stream_data;
  logic                         stream_valid;
  logic                         stream_ready;
  logic [CH_W-1:0]              stream_ch;
  logic [TAP_W-1:0]             stream_tap;
  logic                         stream_last;
  logic                         cfg_err;

  modport master (
    output window_in, window_valid, cfg_mode, cfg_dilation, stream_ready,
    input  window_ready, stream_data, stream_valid, stream_ch, stream_tap,
           stream_last, cfg_err
  );

  modport slave (
    input  window_in, window_valid, cfg_mode, cfg_dilation, stream_ready,
    output window_ready, stream_data, stream_valid, stream_ch, stream_tap,
           stream_last, cfg_err
  );
endinterface

// File: rtl/window_tap_serializer.sv
// Captures a multi-channel sample window and replays it as a tagged scalar beat stream,
// either the newest sample per channel or KERNEL_SIZE dilated taps per channel.
//
// state  | meaning
// IDLE   | no window held, ready for a new one
// STREAM | window held, beats being emitted
module window_tap_serializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_SIZE = 32,
  parameter int NUM_CH      = 4,
  parameter int KERNEL_SIZE = 4,
  parameter int DIL_W       = 5
) (
  input logic                    clk,
  input logic                    rst,
  window_tap_serializer_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAP_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int WI_W  = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
  localparam int IDX_W = $clog2(WINDOW_SIZE) + DIL_W + $clog2(KERNEL_SIZE) + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] win_q [0:NUM_CH-1][0:WINDOW_SIZE-1];
  logic                         mode_q;
  logic [DIL_W-1:0]             dil_q;

  logic signed [DATA_WIDTH-1:0] data_q;
  logic                         valid_q;
  logic [CH_W-1:0]              ch_q;
  logic [TAP_W-1:0]             tap_q;
  logic                         last_q;
  logic                         oor_q;
  logic                         err_q;

  logic                         hs;
  logic                         last_hs;
  logic                         ready;
  logic                         accept;
  logic [DIL_W-1:0]             dil_in;
  logic [WI_W:0]                first_pos;
  logic [WI_W:0]                nxt_pos;
  logic                         first_last;
  logic [CH_W-1:0]              ch_nxt;
  logic [TAP_W-1:0]             tap_nxt;
  logic                         last_nxt;

  // Returns {out_of_range, sample_index} for a tap; arithmetic is wide enough never to wrap.
  function automatic logic [WI_W:0] tap_pos(input logic mode, input logic [DIL_W-1:0] dil,
                                            input logic [TAP_W-1:0] tap);
    logic [IDX_W-1:0] off;
    logic [IDX_W-1:0] newest;
    logic [IDX_W-1:0] diff;
    newest = IDX_W'(WINDOW_SIZE - 1);
    off    = (IDX_W'(KERNEL_SIZE - 1) - IDX_W'(tap)) * IDX_W'(dil);
    diff   = newest - off;
    if (!mode) return {1'b0, WI_W'(WINDOW_SIZE - 1)};
    if (off > newest) return {1'b1, {WI_W{1'b0}}};
    return {1'b0, diff[WI_W-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    hs        = valid_q && bus.stream_ready;
    last_hs   = hs && last_q;
    ready     = !rst && (state == IDLE || last_hs);
    accept    = bus.window_valid && ready;
    state_nxt = state;
    if (accept)       state_nxt = STREAM;
    else if (last_hs) state_nxt = IDLE;
  end

  always_comb begin
    dil_in     = (bus.cfg_dilation == '0) ? DIL_W'(1) : bus.cfg_dilation;
    first_pos  = tap_pos(bus.cfg_mode, dil_in, '0);
    first_last = (NUM_CH == 1) && (!bus.cfg_mode || KERNEL_SIZE == 1);
    ch_nxt     = ch_q;
    tap_nxt    = '0;
    if (!mode_q || tap_q == TAP_W'(KERNEL_SIZE - 1)) begin
      ch_nxt  = ch_q + CH_W'(1);
      tap_nxt = '0;
    end else begin
      tap_nxt = tap_q + TAP_W'(1);
    end
    last_nxt = (ch_nxt == CH_W'(NUM_CH - 1)) &&
               (!mode_q || tap_nxt == TAP_W'(KERNEL_SIZE - 1));
    nxt_pos  = tap_pos(mode_q, dil_q, tap_nxt);
  end

  // Private copy of the window so the source may move on once it has been accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q  <= bus.window_in;
      mode_q <= bus.cfg_mode;
      dil_q  <= dil_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      tap_q   <= '0;
      last_q  <= 1'b0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (hs && oor_q) err_q <= 1'b1;
      if (accept) begin
        valid_q <= 1'b1;
        ch_q    <= '0;
        tap_q   <= '0;
        last_q  <= first_last;
        oor_q   <= first_pos[WI_W];
        data_q  <= first_pos[WI_W] ? '0 : bus.window_in[0][first_pos[WI_W-1:0]];
      end else if (last_hs) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        ch_q    <= '0;
        tap_q   <= '0;
        last_q  <= 1'b0;
        oor_q   <= 1'b0;
      end else if (hs) begin
        ch_q    <= ch_nxt;
        tap_q   <= tap_nxt;
        last_q  <= last_nxt;
        oor_q   <= nxt_pos[WI_W];
        data_q  <= nxt_pos[WI_W] ? '0 : win_q[ch_nxt][nxt_pos[WI_W-1:0]];
      end
    end
  end

  assign bus.window_ready = ready;
  assign bus.stream_data  = data_q;
  assign bus.stream_valid = valid_q;
  assign bus.stream_ch    = ch_q;
  assign bus.stream_tap   = tap_q;
  assign bus.stream_last  = last_q;
  assign bus.cfg_err      = err_q;

  hold_when_stalled: assert property (@(posedge clk) disable iff (rst)
    (valid_q && !bus.stream_ready) |=>
      (valid_q && $stable(data_q) && $stable(ch_q) && $stable(tap_q) && $stable(last_q)));
endmodule

// File: tb/tb_window_tap_serializer.sv
// Self-checking bench for window_tap_serializer: directed vector table, hand-written
// back-to-back/reset sequence, and randomized traffic against a queue-based model.
module tb_window_tap_serializer;
  localparam int DW  = 16;
  localparam int WS  = 32;
  localparam int NC  = 4;
  localparam int KS  = 4;
  localparam int DLW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_tap_serializer_if #(.DATA_WIDTH(DW), .WINDOW_SIZE(WS), .NUM_CH(NC),
                             .KERNEL_SIZE(KS), .DIL_W(DLW)) bus ();

  window_tap_serializer #(.DATA_WIDTH(DW), .WINDOW_SIZE(WS), .NUM_CH(NC),
                          .KERNEL_SIZE(KS), .DIL_W(DLW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [DW-1:0] data;
    int                   ch;
    int                   tap;
    bit                   last;
    bit                   oor;
  } beat_t;

  typedef struct {
    bit mode;
    int dil;
    bit toggle;
    int nbeats;
    int first4 [4];
    bit err;
  } vec_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    exp_err  = 1'b0;
  int    acc_cnt  = 0;
  int    hs_cnt   = 0;
  bit    pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_pattern(input int base);
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < WS; i++)
        bus.window_in[c][i] = DW'(base + c * 256 + i);
  endtask

  // Expected beats for the window and config currently on the inputs.
  task automatic push_model();
    int    d;
    int    idx;
    beat_t b;
    d = (bus.cfg_dilation == 0) ? 1 : int'(bus.cfg_dilation);
    for (int c = 0; c < NC; c++) begin
      if (!bus.cfg_mode) begin
        b.data = bus.window_in[c][WS-1];
        b.ch = c; b.tap = 0; b.last = (c == NC - 1); b.oor = 1'b0;
        exp_q.push_back(b);
      end else begin
        for (int k = 0; k < KS; k++) begin
          idx   = (WS - 1) - (KS - 1 - k) * d;
          b.oor = (idx < 0);
          if (b.oor) b.data = '0;
          else       b.data = bus.window_in[c][idx];
          b.ch = c; b.tap = k; b.last = (c == NC - 1) && (k == KS - 1);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // One clock: called just after a negedge with inputs set, returns at the next negedge.
  task automatic step();
    bit                   hs, acc, stall, was_rst;
    beat_t                e, g;
    logic signed [DW-1:0] p_data;
    int                   p_ch, p_tap;
    bit                   p_last;
    #1;
    was_rst = rst;
    hs      = bus.stream_valid && bus.stream_ready;
    check("window_ready", bus.window_ready,
          !rst && (exp_q.size() == 0 || (hs && exp_q[0].last)));
    acc     = bus.window_valid && bus.window_ready;
    stall   = bus.stream_valid && !bus.stream_ready;
    p_data  = bus.stream_data;
    p_ch    = int'(bus.stream_ch);
    p_tap   = int'(bus.stream_tap);
    p_last  = bus.stream_last;
    if (!was_rst) begin
      if (hs) begin
        g.data = bus.stream_data; g.ch = int'(bus.stream_ch); g.tap = int'(bus.stream_tap);
        g.last = bus.stream_last; g.oor = 1'b0;
        got_q.push_back(g);
        hs_cnt++;
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_data", $signed(bus.stream_data), e.data);
          check("beat_ch", bus.stream_ch, e.ch);
          check("beat_tap", bus.stream_tap, e.tap);
          check("beat_last", bus.stream_last, e.last);
          if (e.oor) exp_err = 1'b1;
        end
      end
      if (acc) begin
        push_model();
        acc_cnt++;
      end
    end
    @(negedge clk);
    if (was_rst) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else if (stall) begin
      check("stall_data", $signed(bus.stream_data), p_data);
      check("stall_ch", bus.stream_ch, p_ch);
      check("stall_tap", bus.stream_tap, p_tap);
      check("stall_last", bus.stream_last, p_last);
    end
    check("cfg_err", bus.cfg_err, exp_err);
    check("stream_valid", bus.stream_valid, exp_q.size() > 0);
  endtask

  task automatic present(input bit mode, input int dil);
    int a0;
    a0 = acc_cnt;
    bus.cfg_mode     = mode;
    bus.cfg_dilation = DLW'(dil);
    bus.window_valid = 1'b1;
    for (int i = 0; i < 40 && acc_cnt == a0; i++) step();
    bus.window_valid = 1'b0;
    check("accept_timeout", acc_cnt, a0 + 1);
  endtask

  task automatic drain(input bit toggle);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      bus.stream_ready = toggle ? pat[i % 4] : 1'b1;
      step();
    end
    bus.stream_ready = 1'b1;
    check("drain_timeout", exp_q.size(), 0);
  endtask

  vec_t vecs [6];
  int   a0, h0, vlow;

  initial begin
    vecs[0] = '{mode: 1'b0, dil: 1,  toggle: 1'b0, nbeats: 4,  first4: '{31, 287, 543, 799}, err: 1'b0};
    vecs[1] = '{mode: 1'b1, dil: 1,  toggle: 1'b0, nbeats: 16, first4: '{28, 29, 30, 31},    err: 1'b0};
    vecs[2] = '{mode: 1'b1, dil: 0,  toggle: 1'b0, nbeats: 16, first4: '{28, 29, 30, 31},    err: 1'b0};
    vecs[3] = '{mode: 1'b1, dil: 2,  toggle: 1'b1, nbeats: 16, first4: '{25, 27, 29, 31},    err: 1'b0};
    vecs[4] = '{mode: 1'b1, dil: 16, toggle: 1'b0, nbeats: 16, first4: '{0, 0, 15, 31},      err: 1'b1};
    vecs[5] = '{mode: 1'b1, dil: 11, toggle: 1'b0, nbeats: 16, first4: '{0, 9, 20, 31},      err: 1'b1};

    rst = 1'b1;
    bus.window_valid = 1'b1;
    bus.stream_ready = 1'b1;
    bus.cfg_mode     = 1'b0;
    bus.cfg_dilation = DLW'(1);
    set_pattern(0);
    @(negedge clk);
    repeat (3) begin
      step();
      check("rst_window_ready", bus.window_ready, 0);
      check("rst_stream_valid", bus.stream_valid, 0);
      check("rst_cfg_err", bus.cfg_err, 0);
    end
    rst = 1'b0;
    bus.window_valid = 1'b0;
    #1;
    check("ready_after_rst", bus.window_ready, 1);

    // Directed table; error vectors come last so the sticky flag carries across them.
    foreach (vecs[v]) begin
      got_q.delete();
      set_pattern(0);
      present(vecs[v].mode, vecs[v].dil);
      drain(vecs[v].toggle);
      check($sformatf("vec%0d_nbeats", v), got_q.size(), vecs[v].nbeats);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
        check($sformatf("vec%0d_beat%0d", v, i), got_q[i].data, vecs[v].first4[i]);
      check($sformatf("vec%0d_cfg_err", v), bus.cfg_err, vecs[v].err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("cfg_err_cleared", bus.cfg_err, 0);

    // Back-to-back windows A then B, then reset in the middle of B.
    got_q.delete();
    set_pattern(0);
    bus.cfg_mode     = 1'b1;
    bus.cfg_dilation = DLW'(1);
    bus.window_valid = 1'b1;
    bus.stream_ready = 1'b1;
    a0 = acc_cnt; h0 = hs_cnt; vlow = 0;
    for (int i = 0; i < 80 && hs_cnt < h0 + 20; i++) begin
      step();
      if (acc_cnt == a0 + 1) set_pattern(4096);
      if (acc_cnt >= a0 + 2) bus.window_valid = 1'b0;
      if (hs_cnt < h0 + 20 && !bus.stream_valid) vlow++;
    end
    check("b2b_beats", hs_cnt, h0 + 20);
    check("b2b_accepts", acc_cnt, a0 + 2);
    check("b2b_valid_low", vlow, 0);
    if (got_q.size() >= 17) begin
      check("b2b_a_last", got_q[15].last, 1);
      check("b2b_b_first", got_q[16].data, 4096 + 28);
    end
    check("b2b_b5_ch", bus.stream_ch, 1);
    rst = 1'b1;
    step();
    check("midrst_valid", bus.stream_valid, 0);
    check("midrst_data", $signed(bus.stream_data), 0);
    check("midrst_ch", bus.stream_ch, 0);
    check("midrst_tap", bus.stream_tap, 0);
    check("midrst_last", bus.stream_last, 0);
    rst = 1'b0;
    got_q.delete();
    set_pattern(0);
    present(1'b1, 3);
    drain(1'b0);
    check("fresh_count", got_q.size(), 16);
    if (got_q.size() > 0) begin
      check("fresh_ch", got_q[0].ch, 0);
      check("fresh_tap", got_q[0].tap, 0);
      check("fresh_data", got_q[0].data, 22);
    end

    // Randomized traffic: inputs and config churn every cycle, including mid-window.
    a0 = acc_cnt;
    for (int cyc = 0; cyc < 4000 && acc_cnt < a0 + 40; cyc++) begin
      bus.stream_ready = ($urandom_range(0, 3) != 0);
      bus.window_valid = ($urandom_range(0, 2) != 0);
      bus.cfg_mode     = ($urandom_range(0, 3) != 0);
      bus.cfg_dilation = DLW'($urandom_range(0, 12));
      for (int c = 0; c < NC; c++)
        for (int i = 0; i < WS; i++)
          bus.window_in[c][i] = DW'($urandom);
      step();
    end
    bus.window_valid = 1'b0;
    check("random_accepts", acc_cnt, a0 + 40);
    drain(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/window_tap_serializer.md
Name: window_tap_serializer

Overview:
- Multi-channel successor to the single-tap window-to-stream bridge.
- Accepts a full parallel window per channel from the window generator and serialises it into a scalar beat stream for the temporal convolution MAC.
- Supports runtime kernel-tap extraction with dilation, a newest-sample-only mode, and valid/ready backpressure on both sides.
- Every output beat is tagged with channel index, tap index and end-of-window marker.

Parameters:
- DATA_WIDTH, 16, sample width (signed)
- WINDOW_SIZE, 32, samples per channel window; index WINDOW_SIZE-1 is newest
- NUM_CH, 4, channels per window
- KERNEL_SIZE, 4, taps emitted per channel in KERNEL mode
- DIL_W, 5, width of cfg_dilation

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- window_in  in  NUM_CH x WINDOW_SIZE x DATA_WIDTH  signed window, unpacked [0:NUM_CH-1][0:WINDOW_SIZE-1]
- window_valid  in  1  window present
- window_ready  out  1  window accepted when valid&ready
- cfg_mode  in  1  0=NEWEST, 1=KERNEL; sampled at window accept
- cfg_dilation  in  DIL_W  tap spacing; sampled at window accept; 0 treated as 1
- stream_data  out  DATA_WIDTH  signed sample
- stream_valid  out  1  beat valid
- stream_ready  in  1  downstream accepts beat
- stream_ch  out  clog2(NUM_CH) (min 1)  channel of beat
- stream_tap  out  clog2(KERNEL_SIZE) (min 1)  tap index, 0=oldest tap
- stream_last  out  1  final beat of current window
- cfg_err  out  1  sticky: an out-of-range tap was emitted

Behaviour:
- Clock/reset: one clock clk. Reset rst is synchronous, active-high.
- Reset values: stream_data=0, stream_valid=0, stream_ch=0, stream_tap=0, stream_last=0, cfg_err=0, state=IDLE. window_ready=0 while rst is high.
- States:
  - IDLE: no window held.
  - STREAM: a window is held and beats are being emitted.
- window_ready (combinational) = !rst && (state==IDLE || (stream_valid && stream_ready && stream_last)).
- On window accept:
  - Capture the entire window into an internal register bank.
  - Latch mode and dilation D (D=max(cfg_dilation,1)).
  - Enter STREAM.
  - First beat is valid the following cycle (latency 1).
- Beat order is channel-major: ch 0..NUM_CH-1; within each channel, tap k 0..KERNEL_SIZE-1.
- KERNEL mode:
  - Sample index = WINDOW_SIZE-1 - (KERNEL_SIZE-1-k)*D.
  - If the index is <0: stream_data=0 and cfg_err is set on that beat's handshake.
  - NUM_CH*KERNEL_SIZE beats per window.
- NEWEST mode: one beat per channel, sample WINDOW_SIZE-1, stream_tap=0. NUM_CH beats per window.
- stream_last=1 only on the final beat of the window.
- Beat advance: occurs only on stream_valid && stream_ready. While stream_valid && !stream_ready, all stream_* outputs hold stable.
- End of window:
  - Final beat handshake with window_valid=1: the new window is accepted in the same cycle and its first beat follows next cycle. No bubble.
  - Final beat handshake with window_valid=0: go IDLE and drop stream_valid next cycle.
- Source isolation: window_in changes after accept do not affect beats in flight (captured copy).
- cfg_mode/cfg_dilation changes mid-window are ignored until the next accept.
- Index arithmetic is unsigned-extended to clog2(WINDOW_SIZE)+DIL_W+clog2(KERNEL_SIZE)+1 bits; no wrap.
- cfg_err is cleared only by rst.
- Reset mid-STREAM: next cycle returns to IDLE with all outputs at reset values; the held window is discarded.

Test Plan:
- Reset & idle: hold rst 3 cycles with window_valid=1 -> window_ready=0, stream_valid=0, cfg_err=0; release rst -> window_ready=1.
- NEWEST mode: window_in[ch][i]=ch*256+i, NUM_CH=4, stream_ready=1 -> 4 beats, data 31, 287, 543, 799; ch 0..3; tap 0; last only on beat 4.
- KERNEL, D=1: same window -> ch0 data 28, 29, 30, 31 (tap 0..3); ch3 data 796..799; 16 beats; last on beat 16.
- KERNEL, D=2 with stream_ready toggled 1,0,0,1,... -> ch0 data 25, 27, 29, 31; outputs stable during every ready=0 cycle; no beat dropped or duplicated.
- Out-of-range, D=16: ch0 -> 0, 0, 15, 31 and cfg_err=1 after beat 1 handshake, staying 1 until rst. Also cfg_dilation=0 -> identical to D=1.
- Back-to-back and reset: two windows presented continuously -> beat 16 of window A is followed next cycle by beat 1 of window B with stream_valid never low. Assert rst at beat 5 of B -> next cycle stream_valid=0, outputs 0; a fresh window after release starts at ch 0, tap 0.
